fetch_ifid: RTL and testbench
=============================

Name: fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Selects the next PC from sequential, branch, jump or jump-register sources.
- Presents the registered instruction fields (rs, rt, immediate, jump field, PC+4 upper nibble) that decode consumes.
- Supports hazard stall and control-flow flush.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, instruction-memory word-address width.

Ports:
- reloj  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold IF/ID and PC
- flush  in  1  squash IF/ID and redirect PC per pc_src
- pc_src  in  2  00 seq (PC+4), 01 branch, 10 jump, 11 jump register
- br_target  in  32  branch target from EX
- jmp_target  in  32  jump target (decode's {pc_4,address,00})
- jr_target  in  32  register target from decode DOA
- imem_req  out  1  fetch request
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_rdata  in  32  instruction word
- imem_ack  in  1  imem_rdata valid this cycle for current imem_addr
- pc  out  32  current fetch PC
- instr  out  32  IF/ID instruction
- id_valid  out  1  IF/ID holds a real instruction
- DIR_A  out  5  instr[25:21]
- DIR_B  out  5  instr[20:16]
- DIR_WRA  out  5  instr[15:11]
- IMD  out  16  instr[15:0]
- address  out  26  instr[25:0]
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- pc_plus4  out  32  PC+4 of the instruction in IF/ID
- pc_4  out  4  pc_plus4[31:28]

Behaviour:
- Reset (sync, highest priority):
  - pc=PC_RESET, state=FETCH, instr=0 (NOP), id_valid=0, pc_plus4=0, skid buffer empty.
  - All field outputs follow instr, so they are all 0.
- Field outputs are pure slices of the registered instr; no extra latency.
- next_pc: pc_src 00 → pc+4; 01 → br_target; 10 → jmp_target; 11 → jr_target.
- Any loaded pc value has bits [1:0] forced to 00. pc+4 wraps modulo 2^32.
- FSM, 2 states:
  - FETCH:
    - imem_req=1.
    - ack & !stall → IF/ID ← {imem_rdata, pc+4, valid=1}; pc ← pc+4.
    - ack & stall → skid ← {imem_rdata, pc+4}; IF/ID holds; pc holds; → WAIT_ID.
    - !ack & !stall → IF/ID ← bubble (instr=0, id_valid=0); pc holds.
    - !ack & stall → everything holds.
  - WAIT_ID:
    - imem_req=0.
    - stall → hold.
    - !stall → IF/ID ← skid with valid=1; pc ← skid PC+4; → FETCH.
- Flush (priority over stall and ack):
  - IF/ID ← bubble, skid discarded, state ← FETCH.
  - pc ← next_pc, except pc_src=00 with flush leaves pc unchanged (refetch).
  - An ack in the same cycle is discarded.
- Memory contract: data on ack always corresponds to the imem_addr of that cycle; a changed address implicitly aborts any pending request.
- Fetch latency: 1 cycle from ack to IF/ID visible; best-case throughput 1 instruction/cycle.
- Reset mid-stall or mid-WAIT_ID: full reset, skid dropped.

Decomposition:
- Package fetch_pkg:
  - pc_src encodings (PCS_SEQ, PCS_BR, PCS_J, PCS_JR).
  - FSM state encoding (ST_FETCH, ST_WAIT_ID).
  - NOP_INSTR = 32'h0.
- Sub-module ifid_reg: IF/ID register with load/hold/bubble controls.
- PC logic and FSM remain in fetch_ifid.

Test Plan:
- Reset, then release → pc=0, imem_addr=0, imem_req=1, instr=0, id_valid=0, DIR_A=DIR_B=IMD=0.
- ack every cycle; mem[0]=32'h2001_0005 → next cycle: instr=32'h20010005, DIR_A=0, DIR_B=1, IMD=16'h0005, pc_plus4=4, pc=4, id_valid=1.
- ack at pc=8 with stall=1 for 3 cycles → IF/ID holds the word from 4, imem_req=0 during WAIT_ID. Stall drops → IF/ID=mem[8], pc_plus4=12, pc=12, imem_req=1.
- Flush with pc_src=10, jmp_target=32'h0040_0102, ack same cycle → id_valid=0, instr=0, pc=32'h0040_0100, imem_addr=pc[IMEM_AW+1:2].
- ack withheld 3 cycles at pc=16 → three bubbles (id_valid=0), pc stays 16. ack → IF/ID=mem[16], pc=20.
- PC_RESET=32'hFFFF_FFFC, ack → pc=0, pc_plus4=0, pc_4=0 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_J   = 2'b10;
  localparam logic [1:0] PCS_JR  = 2'b11;

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_WAIT_ID = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset and bubble insert a NOP, load captures a new
// instruction, otherwise the contents hold.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        id_valid
);

  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic        valid_r;

  // IF/ID register update with reset > bubble > load > hold priority.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (load) begin
      instr_r    <= load_instr;
      pc_plus4_r <= load_pc_plus4;
      valid_r    <= 1'b1;
    end else begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end
  end

  assign instr    = instr_r;
  assign pc_plus4 = pc_plus4_r;
  assign id_valid = valid_r;

endmodule

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage: PC register, next-PC select, req/ack fetch FSM with a
// one-entry skid for words that arrive during a stall, and the IF/ID register.
module fetch_ifid
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               reloj,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [1:0]         pc_src,
  input  logic [31:0]        br_target,
  input  logic [31:0]        jmp_target,
  input  logic [31:0]        jr_target,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ack,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic               id_valid,
  output logic [4:0]         DIR_A,
  output logic [4:0]         DIR_B,
  output logic [4:0]         DIR_WRA,
  output logic [15:0]        IMD,
  output logic [25:0]        address,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic [31:0]        pc_plus4,
  output logic [3:0]         pc_4
);

  fetch_state_t state_r, state_nx_s;
  logic [31:0]  pc_r, pc_nx_s;
  logic [31:0]  skid_instr_r, skid_pc4_r;
  logic         skid_load_s;
  logic [31:0]  pc_inc_s, next_pc_s;
  logic         ifid_load_s, ifid_bubble_s;
  logic [31:0]  ifid_instr_s, ifid_pc4_s;

  assign pc_inc_s = pc_r + 32'd4;

  // Redirect source selection.
  always_comb begin
    next_pc_s = pc_inc_s;
    case (pc_src)
      PCS_SEQ: next_pc_s = pc_inc_s;
      PCS_BR:  next_pc_s = br_target;
      PCS_J:   next_pc_s = jmp_target;
      PCS_JR:  next_pc_s = jr_target;
      default: next_pc_s = pc_inc_s;
    endcase
  end

  // Fetch FSM next state, PC update and IF/ID / skid controls.
  always_comb begin
    state_nx_s    = state_r;
    pc_nx_s       = pc_r;
    skid_load_s   = 1'b0;
    ifid_load_s   = 1'b0;
    ifid_bubble_s = 1'b0;
    ifid_instr_s  = imem_rdata;
    ifid_pc4_s    = pc_inc_s;
    if (flush) begin
      // Sequential flush refetches the current PC; any ack this cycle is dropped.
      ifid_bubble_s = 1'b1;
      state_nx_s    = ST_FETCH;
      if (pc_src == PCS_SEQ) begin
        pc_nx_s = pc_r;
      end else begin
        pc_nx_s = word_align(next_pc_s);
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_ack && !stall) begin
            ifid_load_s = 1'b1;
            pc_nx_s     = pc_inc_s;
          end else if (imem_ack && stall) begin
            skid_load_s = 1'b1;
            state_nx_s  = ST_WAIT_ID;
          end else if (!stall) begin
            ifid_bubble_s = 1'b1;
          end else begin
            state_nx_s = ST_FETCH;
          end
        end
        ST_WAIT_ID: begin
          if (!stall) begin
            ifid_load_s  = 1'b1;
            ifid_instr_s = skid_instr_r;
            ifid_pc4_s   = skid_pc4_r;
            pc_nx_s      = skid_pc4_r;
            state_nx_s   = ST_FETCH;
          end else begin
            state_nx_s = ST_WAIT_ID;
          end
        end
        default: begin
          state_nx_s = ST_FETCH;
        end
      endcase
    end
  end

  // State, PC and skid registers.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= word_align(PC_RESET);
      skid_instr_r <= NOP_INSTR;
      skid_pc4_r   <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      pc_r    <= pc_nx_s;
      if (flush) begin
        skid_instr_r <= NOP_INSTR;
        skid_pc4_r   <= 32'h0000_0000;
      end else if (skid_load_s) begin
        skid_instr_r <= imem_rdata;
        skid_pc4_r   <= pc_inc_s;
      end else begin
        skid_instr_r <= skid_instr_r;
        skid_pc4_r   <= skid_pc4_r;
      end
    end
  end

  ifid_reg u_ifid (
    .clk           (reloj),
    .reset         (reset),
    .load          (ifid_load_s),
    .bubble        (ifid_bubble_s),
    .load_instr    (ifid_instr_s),
    .load_pc_plus4 (ifid_pc4_s),
    .instr         (instr),
    .pc_plus4      (pc_plus4),
    .id_valid      (id_valid)
  );

  assign imem_req  = (state_r == ST_FETCH);
  assign imem_addr = pc_r[IMEM_AW+1:2];
  assign pc        = pc_r;

  assign DIR_A   = instr[25:21];
  assign DIR_B   = instr[20:16];
  assign DIR_WRA = instr[15:11];
  assign IMD     = instr[15:0];
  assign address = instr[25:0];
  assign opcode  = instr[31:26];
  assign funct   = instr[5:0];
  assign pc_4    = pc_plus4[31:28];

endmodule

// File: tb/tb_fetch_ifid.sv
// Randomized self-checking bench for fetch_ifid against a behavioural fetch model,
// with directed scenarios pinned by literal expectations.
module tb_fetch_ifid;

  localparam int AW = 10;

  logic          reloj = 1'b0;
  logic          reset, stall, flush, imem_ack;
  logic [1:0]    pc_src;
  logic [31:0]   br_target, jmp_target, jr_target, imem_rdata;
  logic          imem_req, id_valid;
  logic [AW-1:0] imem_addr;
  logic [31:0]   pc, instr, pc_plus4;
  logic [4:0]    DIR_A, DIR_B, DIR_WRA;
  logic [15:0]   IMD;
  logic [25:0]   address;
  logic [5:0]    opcode, funct;
  logic [3:0]    pc_4;

  logic          w_imem_req, w_id_valid;
  logic [AW-1:0] w_imem_addr;
  logic [31:0]   w_pc, w_instr, w_pc_plus4;
  logic [4:0]    w_dir_a, w_dir_b, w_dir_wra;
  logic [15:0]   w_imd;
  logic [25:0]   w_address;
  logic [5:0]    w_opcode, w_funct;
  logic [3:0]    w_pc_4;

  logic [31:0] mem [0:(1<<AW)-1];
  assign imem_rdata = mem[imem_addr];

  always #5 reloj = ~reloj;

  fetch_ifid #(.PC_RESET(32'h0000_0000), .IMEM_AW(AW)) u_dut (
    .reloj(reloj), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
    .br_target(br_target), .jmp_target(jmp_target), .jr_target(jr_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .instr(instr), .id_valid(id_valid),
    .DIR_A(DIR_A), .DIR_B(DIR_B), .DIR_WRA(DIR_WRA), .IMD(IMD), .address(address),
    .opcode(opcode), .funct(funct), .pc_plus4(pc_plus4), .pc_4(pc_4)
  );

  // Second instance only exercises the PC wrap out of a top-of-memory reset PC.
  fetch_ifid #(.PC_RESET(32'hFFFF_FFFC), .IMEM_AW(AW)) u_dut_wrap (
    .reloj(reloj), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
    .br_target(br_target), .jmp_target(jmp_target), .jr_target(jr_target),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(w_pc), .instr(w_instr), .id_valid(w_id_valid),
    .DIR_A(w_dir_a), .DIR_B(w_dir_b), .DIR_WRA(w_dir_wra), .IMD(w_imd),
    .address(w_address), .opcode(w_opcode), .funct(w_funct),
    .pc_plus4(w_pc_plus4), .pc_4(w_pc_4)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: the PC, what decode sees, and the word parked by a stall.
  typedef struct { logic [31:0] word; logic [31:0] next_pc; } parked_t;
  parked_t     parked_q[$];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[AW+1:2]];
    if (reset) begin
      m_pc = 32'h0000_0000; m_instr = 32'h0; m_valid = 1'b0; m_pc4 = 32'h0;
      parked_q.delete();
    end else if (flush) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc4 = 32'h0;
      parked_q.delete();
      case (pc_src)
        2'b01:   m_pc = br_target  & ~32'd3;
        2'b10:   m_pc = jmp_target & ~32'd3;
        2'b11:   m_pc = jr_target  & ~32'd3;
        default: m_pc = m_pc;
      endcase
    end else if (parked_q.size() != 0) begin
      if (!stall) begin
        parked_t p;
        p = parked_q.pop_front();
        m_instr = p.word; m_pc4 = p.next_pc; m_valid = 1'b1; m_pc = p.next_pc;
      end
    end else if (imem_ack) begin
      if (stall) parked_q.push_back('{word: word, next_pc: m_pc + 32'd4});
      else begin
        m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc4 = 32'h0;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge reloj) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("imem_req", 32'(imem_req), 32'(parked_q.size() == 0));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[AW+1:2]));
      chk("id_valid", 32'(id_valid), 32'(m_valid));
      chk("instr", instr, m_instr);
      chk("DIR_A", 32'(DIR_A), 32'(m_instr[25:21]));
      chk("DIR_B", 32'(DIR_B), 32'(m_instr[20:16]));
      chk("DIR_WRA", 32'(DIR_WRA), 32'(m_instr[15:11]));
      chk("IMD", 32'(IMD), 32'(m_instr[15:0]));
      chk("address", 32'(address), 32'(m_instr[25:0]));
      chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
      chk("funct", 32'(funct), 32'(m_instr[5:0]));
      if (m_valid) begin
        chk("pc_plus4", pc_plus4, m_pc4);
        chk("pc_4", 32'(pc_4), 32'(m_pc4[31:28]));
      end
    end
  end

  task automatic cycle(input logic r, input logic s, input logic f, input logic [1:0] src,
                       input logic a, input logic [31:0] j);
    @(negedge reloj); #1;
    reset = r; stall = s; flush = f; pc_src = src; imem_ack = a;
    jmp_target = j; br_target = $urandom; jr_target = $urandom;
    model_step();
    @(posedge reloj); #1;
  endtask

  initial begin
    logic [31:0] w4, w8, w12, w16;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0005;
    w4 = mem[1]; w8 = mem[2]; w12 = mem[3]; w16 = mem[4];
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_src = 2'b00; imem_ack = 1'b0;
    br_target = 32'h0; jmp_target = 32'h0; jr_target = 32'h0;

    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    chk_en = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_fields", {DIR_A, DIR_B, IMD}, 32'h0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);

    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    chk("first_instr", instr, 32'h2001_0005);
    chk("first_dira", 32'(DIR_A), 32'd0);
    chk("first_dirb", 32'(DIR_B), 32'd1);
    chk("first_imd", 32'(IMD), 32'h0005);
    chk("first_pc4", pc_plus4, 32'd4);
    chk("first_pc", pc, 32'd4);
    chk("first_valid", 32'(id_valid), 32'd1);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_pc_plus4", w_pc_plus4, 32'h0);
    chk("wrap_pc_4", 32'(w_pc_4), 32'd0);

    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0);
    chk("stall_hold_instr", instr, w4);
    chk("wait_req", 32'(imem_req), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("wait_hold_instr", instr, w4);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
    chk("skid_instr", instr, w8);
    chk("skid_pc4", pc_plus4, 32'd12);
    chk("skid_pc", pc, 32'd12);
    chk("skid_req", 32'(imem_req), 32'd1);

    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    chk("pc16_instr", instr, w12);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
      chk("bubble_valid", 32'(id_valid), 32'd0);
      chk("bubble_pc", pc, 32'd16);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
    chk("late_ack_instr", instr, w16);
    chk("late_ack_pc", pc, 32'd20);

    cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 32'h0040_0102);
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_instr", instr, 32'h0);
    chk("flush_pc", pc, 32'h0040_0100);
    chk("flush_addr", 32'(imem_addr), 32'h0000_0040);
    cycle(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0);
    chk("seq_flush_pc", pc, 32'h0040_0100);

    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(2) == 0), ($urandom_range(9) == 0),
            2'($urandom_range(3)), ($urandom_range(2) != 0), $urandom);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
